// File: rtl/n_bit_alu.sv
// n_bit_alu: parameterised N-bit integer ALU with combinational result/flags
// and a one-cycle registered copy of the result and zero flag.
// Optional shift opcodes (SLL/SRL/SRA) are compiled in when the macro
// ALU_SHIFT_OPS_EN is defined; otherwise those codes behave as unassigned.

module n_bit_alu #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [3:0]   sel,
   output logic [N-1:0] alu_out,
   output logic         zflag,
   output logic         carry,
   output logic         overflow,
   output logic [N-1:0] alu_out_q,
   output logic         zflag_q
);

   // Operation encodings
   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_XOR  = 4'b1000;
   localparam logic [3:0] OP_SLTU = 4'b1001;
   localparam logic [3:0] OP_NOR  = 4'b1101;
`ifdef ALU_SHIFT_OPS_EN
   localparam logic [3:0] OP_SLL  = 4'b0011;
   localparam logic [3:0] OP_SRL  = 4'b0100;
   localparam logic [3:0] OP_SRA  = 4'b0101;
   localparam int         SHW     = $clog2(N);
`endif

   // Reduction helper: 1 when the whole vector is zero
   function automatic logic is_zero(input logic [N-1:0] v);
      return ~(|v);
   endfunction

   // Signed overflow of a+b: operands agree in sign, result disagrees
   function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
      return (sa == sb) && (sr != sa);
   endfunction

   // Signed overflow of a-b: operands differ in sign, result differs from a
   function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
      return (sa != sb) && (sr != sa);
   endfunction

   logic [N:0]   sum_s;       // a + b with carry-out in bit N
   logic [N:0]   diff_s;      // a + ~b + 1 with carry-out (no-borrow) in bit N
   logic         add_ovf_s;
   logic         sub_ovf_s;
   logic         slt_s;
   logic         sltu_s;
   logic [N-1:0] result_s;
   logic         carry_s;
   logic         ovf_s;
`ifdef ALU_SHIFT_OPS_EN
   logic [SHW-1:0] sh_s;
   logic [N-1:0]   sll_s;
   logic [N-1:0]   srl_s;
   logic [N-1:0]   sra_s;
`endif

   // Shared adder/subtractor and the comparison results derived from them
   always_comb begin
      sum_s     = {1'b0, a} + {1'b0, b};
      diff_s    = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
      add_ovf_s = add_ovf(a[N-1], b[N-1], sum_s[N-1]);
      sub_ovf_s = sub_ovf(a[N-1], b[N-1], diff_s[N-1]);
      // Signed less-than stays correct at the extremes via sign XOR overflow
      slt_s     = diff_s[N-1] ^ sub_ovf_s;
      // Carry-out of the subtract is 1 exactly when a >= b unsigned
      sltu_s    = ~diff_s[N];
   end

`ifdef ALU_SHIFT_OPS_EN
   // Barrel shifter; only the low log2(N) bits of b set the shift amount
   always_comb begin
      sh_s  = b[SHW-1:0];
      sll_s = a << sh_s;
      srl_s = a >> sh_s;
      sra_s = $unsigned($signed(a) >>> sh_s);
   end
`endif

   // Result and flag select; unassigned codes yield a defined zero result
   always_comb begin
      result_s = {N{1'b0}};
      carry_s  = 1'b0;
      ovf_s    = 1'b0;
      case (sel)
         OP_AND:  result_s = a & b;
         OP_OR:   result_s = a | b;
         OP_ADD: begin
            result_s = sum_s[N-1:0];
            carry_s  = sum_s[N];
            ovf_s    = add_ovf_s;
         end
         OP_SUB: begin
            result_s = diff_s[N-1:0];
            carry_s  = diff_s[N];
            ovf_s    = sub_ovf_s;
         end
         OP_SLT:  result_s = {{(N-1){1'b0}}, slt_s};
         OP_XOR:  result_s = a ^ b;
         OP_SLTU: result_s = {{(N-1){1'b0}}, sltu_s};
         OP_NOR:  result_s = ~(a | b);
`ifdef ALU_SHIFT_OPS_EN
         OP_SLL:  result_s = sll_s;
         OP_SRL:  result_s = srl_s;
         OP_SRA:  result_s = sra_s;
`endif
         default: result_s = {N{1'b0}};
      endcase
   end

   // Drive combinational outputs; zero flag follows the final result
   always_comb begin
      alu_out  = result_s;
      zflag    = is_zero(result_s);
      carry    = carry_s;
      overflow = ovf_s;
   end

   // Pipeline register: reset state matches a zero result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_out_q <= {N{1'b0}};
         zflag_q   <= 1'b1;
      end else begin
         alu_out_q <= result_s;
         zflag_q   <= is_zero(result_s);
      end
   end

endmodule

// File: tb/tb_n_bit_alu.sv
// Directed self-checking bench for n_bit_alu (N=32). Shift vectors are
// selected by the ALU_SHIFT_OPS_EN macro to match the build under test.

module tb_n_bit_alu;

   localparam int N = 32;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [3:0]   sel;
   logic [N-1:0] alu_out;
   logic         zflag;
   logic         carry;
   logic         overflow;
   logic [N-1:0] alu_out_q;
   logic         zflag_q;

   int checks_r;
   int errors_r;

   n_bit_alu #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .sel       (sel),
      .alu_out   (alu_out),
      .zflag     (zflag),
      .carry     (carry),
      .overflow  (overflow),
      .alu_out_q (alu_out_q),
      .zflag_q   (zflag_q)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: count and report any mismatch
   task automatic check_val(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      checks_r = checks_r + 1;
      if (got !== exp) begin
         errors_r = errors_r + 1;
         $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Drive one vector, let it settle, check result and all flags
   task automatic run_op(input string tag, input logic [3:0] s, input logic [N-1:0] va,
                         input logic [N-1:0] vb, input logic [N-1:0] e_out, input logic e_z,
                         input logic e_c, input logic e_v);
      sel = s;
      a   = va;
      b   = vb;
      #1;
      check_val({tag, ".out"}, alu_out, e_out);
      check_val({tag, ".z"}, {31'd0, zflag}, {31'd0, e_z});
      check_val({tag, ".c"}, {31'd0, carry}, {31'd0, e_c});
      check_val({tag, ".v"}, {31'd0, overflow}, {31'd0, e_v});
   endtask

   initial begin
      checks_r = 0;
      errors_r = 0;
      rst_n = 1'b0;
      a     = 32'd0;
      b     = 32'd0;
      sel   = 4'b0000;

      // Reset state of the registered outputs
      @(posedge clk);
      #1;
      check_val("rst.q", alu_out_q, 32'd0);
      check_val("rst.zq", {31'd0, zflag_q}, 32'd1);

      // Basic operations with a=16, b=12
      run_op("and",  4'b0000, 32'd16, 32'd12, 32'd0,  1'b1, 1'b0, 1'b0);
      run_op("sub",  4'b0110, 32'd16, 32'd12, 32'd4,  1'b0, 1'b1, 1'b0);
      run_op("add",  4'b0010, 32'd16, 32'd12, 32'd28, 1'b0, 1'b0, 1'b0);
      run_op("or",   4'b0001, 32'd16, 32'd12, 32'd28, 1'b0, 1'b0, 1'b0);
      run_op("c1100",4'b1100, 32'd16, 32'd12, 32'd0,  1'b1, 1'b0, 1'b0);
      run_op("c1111",4'b1111, 32'd16, 32'd12, 32'd0,  1'b1, 1'b0, 1'b0);

      // Add/sub extremes
      run_op("addwrap", 4'b0010, 32'hFFFFFFFF, 32'd1, 32'd0,        1'b1, 1'b1, 1'b0);
      run_op("addovf",  4'b0010, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b0, 1'b1);
      run_op("subneg",  4'b0110, 32'd12, 32'd16, 32'hFFFFFFFC,      1'b0, 1'b0, 1'b0);
      run_op("subovf",  4'b0110, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1);

      // Comparisons
      run_op("slt1",    4'b0111, 32'd12, 32'd16, 32'd1, 1'b0, 1'b0, 1'b0);
      run_op("slt0",    4'b0111, 32'd16, 32'd12, 32'd0, 1'b1, 1'b0, 1'b0);
      run_op("sltext",  4'b0111, 32'h80000000, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
      run_op("sltu0",   4'b1001, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0);
      run_op("sltu1",   4'b1001, 32'd1, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 1'b0);

      // Bitwise
      run_op("xor", 4'b1000, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 1'b0, 1'b0, 1'b0);
      run_op("nor", 4'b1101, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);

`ifdef ALU_SHIFT_OPS_EN
      run_op("sll",   4'b0011, 32'd1, 32'd31, 32'h80000000, 1'b0, 1'b0, 1'b0);
      run_op("sra",   4'b0101, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1'b0, 1'b0);
      run_op("srl",   4'b0100, 32'h80000000, 32'd4, 32'h08000000, 1'b0, 1'b0, 1'b0);
      run_op("sllhi", 4'b0011, 32'd1, 32'h23, 32'd8, 1'b0, 1'b0, 1'b0);
`else
      run_op("u0011", 4'b0011, 32'd1, 32'd31, 32'd0, 1'b1, 1'b0, 1'b0);
      run_op("u0100", 4'b0100, 32'h80000000, 32'd4, 32'd0, 1'b1, 1'b0, 1'b0);
      run_op("u0101", 4'b0101, 32'h80000000, 32'd4, 32'd0, 1'b1, 1'b0, 1'b0);
`endif

      // Registered path: hold reset, then release and capture ADD 16+12
      @(negedge clk);
      rst_n = 1'b0;
      sel   = 4'b0010;
      a     = 32'd16;
      b     = 32'd12;
      #1;
      check_val("hold.q", alu_out_q, 32'd0);
      check_val("hold.zq", {31'd0, zflag_q}, 32'd1);
      check_val("hold.comb", alu_out, 32'd28);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_val("reg.q", alu_out_q, 32'd28);
      check_val("reg.zq", {31'd0, zflag_q}, 32'd0);

      // Async reset between edges clears the registers at once
      #2;
      rst_n = 1'b0;
      #1;
      check_val("async.q", alu_out_q, 32'd0);
      check_val("async.zq", {31'd0, zflag_q}, 32'd1);
      check_val("async.comb", alu_out, 32'd28);

      // First edge after release captures the current result (SUB 16-12)
      @(negedge clk);
      sel   = 4'b0110;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_val("rel.q", alu_out_q, 32'd4);
      check_val("rel.zq", {31'd0, zflag_q}, 32'd0);

      // Zero result propagates to the registered zero flag
      sel = 4'b1100;
      @(posedge clk);
      #1;
      check_val("zero.q", alu_out_q, 32'd0);
      check_val("zero.zq", {31'd0, zflag_q}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
      $finish;
   end

endmodule
